// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the multi-channel DDS waveform generator:
// shape selector, config register map, quarter-sine table and noise LFSR setup.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_sel_e;

  localparam logic [2:0] CFG_FTW      = 3'd0;
  localparam logic [2:0] CFG_AMP      = 3'd1;
  localparam logic [2:0] CFG_WAVE_SEL = 3'd2;
  localparam logic [2:0] CFG_DUTY     = 3'd3;
  localparam logic [2:0] CFG_CTRL     = 3'd4;

  // round(127*sin((i+0.5)*pi/128)); half-step offset keeps the quadrant mirror symmetric
  localparam logic [6:0] SINE_Q [64] = '{
      7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
      7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
      7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
      7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
      7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
      7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
      7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/wave_shape.sv
// Combinational shape lookup: truncated phase p plus selector/duty -> signed
// DATA_W sample (sine, square, saw, triangle).
module wave_shape
  import wave_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]        p,
  input  wave_sel_e                sel,
  input  logic [DATA_W-1:0]        duty,
  output logic signed [DATA_W-1:0] shape
);

  localparam logic signed [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic [1:0]        quad;
  logic [5:0]        idx;
  logic [DATA_W-1:0] sine_mag;
  logic [DATA_W-2:0] tri_t;

  always_comb begin
    quad     = p[DATA_W-1 -: 2];
    // quadrants 1 and 3 walk the table backwards
    idx      = quad[0] ? ~p[DATA_W-3 -: 6] : p[DATA_W-3 -: 6];
    sine_mag = DATA_W'({1'b0, SINE_Q[idx]}) << (DATA_W - 8);
    tri_t    = p[DATA_W-1] ? ~p[DATA_W-2:0] : p[DATA_W-2:0];
    case (sel)
      WAVE_SINE:   shape = quad[1] ? -sine_mag : sine_mag;
      WAVE_SQUARE: shape = (p < duty) ? MAX : -MAX;
      WAVE_SAW:    shape = {~p[DATA_W-1], p[DATA_W-2:0]};
      default:     shape = {~tri_t[DATA_W-2], tri_t[DATA_W-3:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/wave_gen_mc.sv
// Multi-channel DDS waveform generator with per-channel config registers and a
// shared sample prescaler. Optional LFSR noise injection: define WAVE_GEN_NOISE_EN.
module wave_gen_mc
  import wave_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 8,
  parameter int PHASE_W    = 16,
  parameter int OUT_W      = 16,
  parameter int SAMPLE_DIV = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [2:0]              cfg_addr,
  input  logic [PHASE_W-1:0]      cfg_wdata,
  input  logic                    phase_sync,
  output logic [NUM_CH*OUT_W-1:0] wave_out,
  output logic                    out_valid
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [DATA_W-1:0]       DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;
  logic             sample_en;
  logic             stage1_valid_reg;
  logic             out_valid_reg;

  assign tick      = (cnt_reg == CNT_W'(SAMPLE_DIV - 1));
  // phase_sync swallows a coinciding tick; earlier samples still drain
  assign sample_en = tick && !phase_sync;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg          <= '0;
      stage1_valid_reg <= 1'b0;
      out_valid_reg    <= 1'b0;
    end else begin
      if (phase_sync || tick) cnt_reg <= '0;
      else                    cnt_reg <= cnt_reg + 1'b1;
      stage1_valid_reg <= sample_en;
      out_valid_reg    <= stage1_valid_reg;
    end
  end

`ifdef WAVE_GEN_NOISE_EN
  logic [15:0]              lfsr_reg;
  logic signed [DATA_W-1:0] noise_reg;

  // noise_reg travels alongside the shape register so one sample set shares one value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg  <= LFSR_SEED;
      noise_reg <= '0;
    end else if (sample_en) begin
      noise_reg <= lfsr_reg[DATA_W-1:0];
      lfsr_reg  <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PHASE_W-1:0]       ftw_reg;
    logic [PHASE_W-1:0]       acc_reg;
    logic signed [DATA_W-1:0] amp_reg;
    wave_sel_e                sel_reg;
    logic [DATA_W-1:0]        duty_reg;
    logic [1:0]               ctrl_reg;
    logic signed [DATA_W-1:0] shape_next;
    logic signed [DATA_W-1:0] shape_reg;
    logic                     en_d1_reg;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic [OUT_W-1:0]         wave_next;
    logic [OUT_W-1:0]         wave_reg;
    logic                     wr;
`ifdef WAVE_GEN_NOISE_EN
    logic                     noise_d1_reg;
`endif

    assign wr = cfg_we && !phase_sync && (cfg_ch == CH_W'(gi));

    wave_shape #(.DATA_W(DATA_W)) u_shape (
      .p     (acc_reg[PHASE_W-1 -: DATA_W]),
      .sel   (sel_reg),
      .duty  (duty_reg),
      .shape (shape_next)
    );

    always_comb begin
      prod = amp_reg * shape_reg;
      sum  = {prod[PROD_W-1], prod};
`ifdef WAVE_GEN_NOISE_EN
      if (noise_d1_reg) sum = sum + {{(SUM_W-DATA_W){noise_reg[DATA_W-1]}}, noise_reg};
`endif
      if (sum > OUT_MAX)      wave_next = OUT_MAX[OUT_W-1:0];
      else if (sum < OUT_MIN) wave_next = OUT_MIN[OUT_W-1:0];
      else                    wave_next = sum[OUT_W-1:0];
      if (!en_d1_reg) wave_next = '0;
    end

    // The shape register samples acc before this tick's increment lands
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ftw_reg   <= '0;
        acc_reg   <= '0;
        amp_reg   <= '0;
        sel_reg   <= WAVE_SINE;
        duty_reg  <= DUTY_RST;
        ctrl_reg  <= '0;
        shape_reg <= '0;
        en_d1_reg <= 1'b0;
        wave_reg  <= '0;
`ifdef WAVE_GEN_NOISE_EN
        noise_d1_reg <= 1'b0;
`endif
      end else begin
        if (wr) begin
          case (cfg_addr)
            CFG_FTW:      ftw_reg  <= cfg_wdata;
            CFG_AMP:      amp_reg  <= cfg_wdata[DATA_W-1:0];
            CFG_WAVE_SEL: sel_reg  <= wave_sel_e'(cfg_wdata[1:0]);
            CFG_DUTY:     duty_reg <= cfg_wdata[DATA_W-1:0];
            CFG_CTRL:     ctrl_reg <= cfg_wdata[1:0];
            default:      ;
          endcase
        end
        if (phase_sync)                acc_reg <= '0;
        else if (tick && ctrl_reg[0])  acc_reg <= acc_reg + ftw_reg;
        if (sample_en) begin
          shape_reg <= shape_next;
          en_d1_reg <= ctrl_reg[0];
`ifdef WAVE_GEN_NOISE_EN
          noise_d1_reg <= ctrl_reg[1];
`endif
        end
        if (stage1_valid_reg) wave_reg <= wave_next;
      end
    end

    assign wave_out[gi*OUT_W +: OUT_W] = wave_reg;
  end

endmodule
